ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF3 typematic) from the host to the keyboard over the same open-drain clock/data pair that the keyboard receive path listens on. It runs the PS/2 request-to-send sequence and shifts out data, odd parity and stop bits on device-generated clock edges. It checks the device's line ACK and reports completion or error. While `busy` is high, the keyboard receive path must be held off (its inputs masked).

---
 rtl/ps2_host_tx_pkg.sv | 25 ++
 rtl/ps2_host_tx_if.sv | 27 ++
 rtl/ps2_host_tx_line_sync.sv | 28 ++
 rtl/ps2_host_tx.sv | 190 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// Also holds the odd-parity helper used when a command byte is latched.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE,
        DONE
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;

    // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and completion status between the host logic and the PS/2 transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchronizer for one open-drain PS/2 pad, plus a falling-edge pulse.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_sync,
    output logic o_fall
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Reset to 1 because an idle PS/2 line is pulled high; this avoids a false fall after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_prev & ~r_sync;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift out a byte on
// device clock falls, then check the device ACK and report done/err.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750_000
) (
    input  logic          clk,
    input  logic          reset,
    ps2_host_tx_if.slave  tx,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    if (CLK_HZ <= 0 || INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_badParams
        $error("ps2_host_tx: invalid parameter values");
    end

    logic w_clkSync;
    logic w_clkFall;
    logic w_dataSync;
    logic w_unusedDataFall;

    ps2_line_sync u_clkSync (
        .clk    (clk),
        .reset  (reset),
        .i_line (ps2_clk_in),
        .o_sync (w_clkSync),
        .o_fall (w_clkFall)
    );

    ps2_line_sync u_dataSync (
        .clk    (clk),
        .reset  (reset),
        .i_line (ps2_data_in),
        .o_sync (w_dataSync),
        .o_fall (w_unusedDataFall)
    );

    ps2_tx_state_t    r_state,   w_nextState;
    logic [INH_W-1:0] r_inhCnt,  w_nextInhCnt;
    logic [TO_W-1:0]  r_toCnt,   w_nextToCnt;
    logic [3:0]       r_bitIdx,  w_nextBitIdx;
    logic [7:0]       r_shift,   w_nextShift;
    logic             r_parity,  w_nextParity;
    logic             r_err,     w_nextErr;
    logic             r_clkOe,   w_nextClkOe;
    logic             r_dataOe,  w_nextDataOe;
    logic             r_done,    w_nextDone;
    logic             r_busy;
    logic             r_ready;
    logic             w_timeout;
    logic             w_timedState;

    assign w_timeout    = (r_toCnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_timedState = (r_state == SEND) || (r_state == ACK) || (r_state == WAIT_IDLE);

    // Every output is registered; busy/ready are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_inhCnt <= '0;
            r_toCnt  <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_err    <= 1'b0;
            r_clkOe  <= 1'b0;
            r_dataOe <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_nextState;
            r_inhCnt <= w_nextInhCnt;
            r_toCnt  <= w_nextToCnt;
            r_bitIdx <= w_nextBitIdx;
            r_shift  <= w_nextShift;
            r_parity <= w_nextParity;
            r_err    <= w_nextErr;
            r_clkOe  <= w_nextClkOe;
            r_dataOe <= w_nextDataOe;
            r_done   <= w_nextDone;
            r_busy   <= (w_nextState != IDLE);
            r_ready  <= (w_nextState == IDLE);
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_nextInhCnt = r_inhCnt;
        w_nextToCnt  = r_toCnt;
        w_nextBitIdx = r_bitIdx;
        w_nextShift  = r_shift;
        w_nextParity = r_parity;
        w_nextErr    = r_err;
        w_nextClkOe  = r_clkOe;
        w_nextDataOe = r_dataOe;
        w_nextDone   = 1'b0;

        // A timeout wins over any fall seen in the same cycle.
        if (w_timedState && w_timeout) begin
            w_nextClkOe  = 1'b0;
            w_nextDataOe = 1'b0;
            w_nextErr    = 1'b1;
            w_nextDone   = 1'b1;
            w_nextState  = DONE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_nextClkOe  = 1'b0;
                    w_nextDataOe = 1'b0;
                    if (tx.tx_valid && r_ready) begin
                        w_nextShift  = tx.tx_data;
                        w_nextParity = odd_parity(tx.tx_data);
                        w_nextErr    = 1'b0;
                        w_nextInhCnt = '0;
                        w_nextClkOe  = 1'b1;
                        w_nextState  = INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (r_inhCnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                        w_nextDataOe = 1'b1;
                        w_nextState  = REQ;
                    end else begin
                        w_nextInhCnt = r_inhCnt + 1'b1;
                    end
                end
                REQ: begin
                    w_nextClkOe  = 1'b0;
                    w_nextToCnt  = '0;
                    w_nextBitIdx = '0;
                    w_nextState  = SEND;
                end
                SEND: begin
                    w_nextToCnt = r_toCnt + 1'b1;
                    if (w_clkFall) begin
                        if (r_bitIdx < 4'd8) begin
                            w_nextDataOe = ~r_shift[r_bitIdx[2:0]];
                        end else if (r_bitIdx == 4'd8) begin
                            w_nextDataOe = ~r_parity;
                        end else begin
                            w_nextDataOe = 1'b0;
                        end
                        w_nextBitIdx = r_bitIdx + 4'd1;
                        if (r_bitIdx == 4'd9) begin
                            w_nextState = ACK;
                        end
                    end
                end
                ACK: begin
                    w_nextToCnt = r_toCnt + 1'b1;
                    if (w_clkFall) begin
                        w_nextErr   = w_dataSync;
                        w_nextState = WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    w_nextToCnt = r_toCnt + 1'b1;
                    if (w_clkSync && w_dataSync) begin
                        w_nextDone  = 1'b1;
                        w_nextState = DONE;
                    end
                end
                DONE: begin
                    w_nextState = IDLE;
                end
                default: begin
                    w_nextClkOe  = 1'b0;
                    w_nextDataOe = 1'b0;
                    w_nextState  = IDLE;
                end
            endcase
        end
    end

    assign ps2_clk_oe  = r_clkOe;
    assign ps2_data_oe = r_dataOe;
    assign tx.tx_ready = r_ready;
    assign tx.busy     = r_busy;
    assign tx.done     = r_done;
    assign tx.err      = r_err;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboarded bench for ps2_host_tx with an open-drain PS/2 keyboard model.
// Stimulus pushes expected outcomes; a monitor pops them whenever done pulses.
module tb_ps2_host_tx;
    localparam int INHIBIT = 5000;
    localparam int TIMEOUT = 3000;
    localparam int HALF    = 20;

    typedef struct {
        logic [7:0] data;
        bit         expErr;
        bit         checkFrame;
        bit         checkTimeout;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic clkOe;
    logic dataOe;
    logic devClkLow;
    logic devDataLow;
    logic clkLine;
    logic dataLine;

    ps2_host_tx_if txIf ();

    assign clkLine  = ~clkOe & ~devClkLow;
    assign dataLine = ~dataOe & ~devDataLow;

    ps2_host_tx #(
        .CLK_HZ         (50_000_000),
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx          (txIf),
        .ps2_clk_in  (clkLine),
        .ps2_data_in (dataLine),
        .ps2_clk_oe  (clkOe),
        .ps2_data_oe (dataOe)
    );

    always #10 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          doneCount = 0;
    int          expDone = 0;
    int          sendStart = 0;
    int          devMode = 0;
    int          devFalls = 0;
    bit          devActive = 1'b0;
    logic [10:0] capFrame;
    exp_t        expQ[$];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Frame as the device should sample it: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] refFrame(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = d[i];
            ones += int'(d[i]);
        end
        f[9]  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    // Keyboard model. Mode 0 ACKs, mode 1 leaves data high on the 11th clock, mode 2 never clocks.
    initial begin : deviceModel
        logic prevClk;
        devClkLow  = 1'b0;
        devDataLow = 1'b0;
        capFrame   = '0;
        prevClk    = 1'b1;
        forever begin
            @(negedge clk);
            if (!prevClk && clkLine && !dataLine && devMode != 2 && !reset) begin
                devActive   = 1'b1;
                devFalls    = 0;
                capFrame[0] = dataLine;
                repeat (HALF) @(negedge clk);
                for (int k = 1; k <= 11; k++) begin
                    devClkLow = 1'b1;
                    devFalls++;
                    repeat (HALF) @(negedge clk);
                    devClkLow = 1'b0;
                    if (k <= 10) capFrame[k] = dataLine;
                    repeat (HALF / 2) @(negedge clk);
                    if (k == 10 && devMode == 0) devDataLow = 1'b1;
                    if (k == 11) devDataLow = 1'b0;
                    repeat (HALF / 2) @(negedge clk);
                end
                devActive = 1'b0;
            end
            prevClk = clkLine;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (txIf.done) begin
                doneCount++;
                checkOutput("queueAtDone", 32'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("err", txIf.err, e.expErr);
                    checkOutput("clkOeAtDone", clkOe, 0);
                    checkOutput("dataOeAtDone", dataOe, 0);
                    if (e.checkFrame) checkOutput("frame", capFrame, refFrame(e.data));
                    if (e.checkTimeout) checkOutput("timeoutCycles", cycle - sendStart, TIMEOUT);
                    @(negedge clk);
                    checkOutput("doneWidth", txIf.done, 0);
                    checkOutput("readyAfterDone", txIf.tx_ready, 1);
                    checkOutput("busyAfterDone", txIf.busy, 0);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] data, input int mode, input bit expectDone,
                                 input bit expErr, input bit checkTimeout);
        int n;
        exp_t e;
        n = 0;
        while ((!txIf.tx_ready || devActive) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("readyBeforeSend", txIf.tx_ready, 1);
        devMode       = mode;
        txIf.tx_data  = data;
        txIf.tx_valid = 1'b1;
        if (expectDone) begin
            e.data         = data;
            e.expErr       = expErr;
            e.checkFrame   = (mode != 2);
            e.checkTimeout = checkTimeout;
            expQ.push_back(e);
            expDone++;
        end
        @(negedge clk);
        txIf.tx_valid = 1'b0;
        checkOutput("busyAfterAccept", txIf.busy, 1);
        checkOutput("readyAfterAccept", txIf.tx_ready, 0);
        checkOutput("clkOeAfterAccept", clkOe, 1);
        n = 0;
        while (clkOe && !dataOe && n < INHIBIT + 10) begin
            n++;
            @(negedge clk);
        end
        checkOutput("inhibitCycles", n, INHIBIT);
        checkOutput("reqClkOe", clkOe, 1);
        checkOutput("reqDataOe", dataOe, 1);
        @(negedge clk);
        checkOutput("sendClkOe", clkOe, 0);
        checkOutput("startBitOe", dataOe, 1);
        sendStart = cycle;
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (doneCount < expDone && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(doneCount >= expDone), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin : stimulus
        int n;
        logic [7:0] rdata;
        int rmode;

        reset         = 1'b1;
        txIf.tx_valid = 1'b0;
        txIf.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("resetReady", txIf.tx_ready, 1);
        checkOutput("resetBusy", txIf.busy, 0);
        checkOutput("resetDone", txIf.done, 0);
        checkOutput("resetErr", txIf.err, 0);
        checkOutput("resetClkOe", clkOe, 0);
        checkOutput("resetDataOe", dataOe, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] send 0xED with ACK");
        applyStimulus(ps2_pkg::CMD_SET_LEDS, 0, 1'b1, 1'b0, 1'b0);
        waitDone("doneEd");

        $display("[TB] send 0x01 with ACK");
        applyStimulus(8'h01, 0, 1'b1, 1'b0, 1'b0);
        waitDone("done01");

        $display("[TB] send 0x5A without ACK");
        applyStimulus(8'h5A, 1, 1'b1, 1'b1, 1'b0);
        waitDone("doneNoAck");

        $display("[TB] send 0x3C to a silent device");
        applyStimulus(8'h3C, 2, 1'b1, 1'b1, 1'b1);
        waitDone("doneTimeout");

        $display("[TB] reset after the 4th fall");
        applyStimulus(ps2_pkg::CMD_SET_LEDS, 0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        n = 0;
        while (devFalls < 4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("fourthFall", 32'(devFalls >= 4), 1);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midResetClkOe", clkOe, 0);
        checkOutput("midResetDataOe", dataOe, 0);
        checkOutput("midResetBusy", txIf.busy, 0);
        checkOutput("midResetDone", txIf.done, 0);
        checkOutput("midResetReady", txIf.tx_ready, 1);
        applyStimulus(8'hF3, 0, 1'b1, 1'b0, 1'b0);
        waitDone("doneF3");

        $display("[TB] tx_valid 0xAA while busy");
        applyStimulus(ps2_pkg::CMD_SET_LEDS, 0, 1'b1, 1'b0, 1'b0);
        repeat (60) @(negedge clk);
        checkOutput("readyWhileBusy", txIf.tx_ready, 0);
        txIf.tx_data  = 8'hAA;
        txIf.tx_valid = 1'b1;
        @(negedge clk);
        txIf.tx_valid = 1'b0;
        waitDone("doneEdIgnore");
        repeat (20) @(negedge clk);
        checkOutput("idleAfterIgnored", txIf.busy, 0);

        for (int i = 0; i < 2; i++) begin
            rdata = 8'($urandom_range(0, 255));
            rmode = int'($urandom_range(0, 1));
            $display("[TB] random byte 0x%02h mode %0d", rdata, rmode);
            applyStimulus(rdata, rmode, 1'b1, rmode == 1, 1'b0);
            waitDone("doneRandom");
        end

        repeat (50) @(negedge clk);
        checkOutput("expQEmpty", expQ.size(), 0);
        checkOutput("doneTotal", doneCount, expDone);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1_800_000;
        $display("[TB] FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
